id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Pipeline register between decode and execute. It captures one decoded instruction per valid/ready handshake, holds it across downstream stalls, and applies MEM/WB forwarding to both operands. It drives A, B and ALUop straight into the 32-bit ALU. It also passes destination and writeback info to the MEM stage and counts stall cycles.

Parameters:
- FWD_EN, 1, 1 enables MEM/WB forwarding; 0 passes register operands through unmodified.
- REG_IDX_W, 5, width of register indices.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  decode holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  32  instruction PC
- in_rs_idx / in_rt_idx / in_rd_idx  in  REG_IDX_W each  source and destination indices
- in_rs_val / in_rt_val  in  32 each  register-file read data
- in_imm  in  32  already-extended immediate
- in_use_imm  in  1  1 selects in_imm as B; rt still tracked for store data
- in_alu_op  in  3  ALU operation code
- in_wen  in  1  instruction writes rd
- fwd_mem_wen, fwd_mem_idx, fwd_mem_val  in  1/REG_IDX_W/32  MEM-stage result
- fwd_wb_wen, fwd_wb_idx, fwd_wb_val  in  1/REG_IDX_W/32  WB-stage result
- flush  in  1  squash held and incoming instruction
- out_valid  out  1  held instruction valid
- out_ready  in  1  MEM stage accepts
- alu_a, alu_b  out  32 each  ALU operands
- alu_op  out  3  ALU operation code
- out_store_data  out  32  forwarded rt value
- out_rd_idx  out  REG_IDX_W
- out_wen  out  1  gated: out_valid AND held wen
- out_pc  out  32
- stall_cnt  out  32  count of stalled cycles

Behaviour:
- Reset, asynchronous, active-high: out_valid=0, every held field=0, alu_op=000 (AND), stall_cnt=0. Reset mid-transfer discards the instruction.
- in_ready = !out_valid || out_ready, combinational.
- Accept when in_valid && in_ready: capture all fields at the edge. Latency is 1 cycle: the instruction appears on the outputs the next cycle.
- Hold when out_valid && !out_ready: fields stay put, except rs/rt values, which refresh every cycle (below).
- Drain when out_ready && !in_valid: out_valid goes 0 next cycle.
- Forward function fwd(idx, v): if FWD_EN and idx!=0 and fwd_mem_wen and fwd_mem_idx==idx, return fwd_mem_val. Else if FWD_EN and idx!=0 and fwd_wb_wen and fwd_wb_idx==idx, return fwd_wb_val. Else return v. MEM has priority over WB; register 0 is never forwarded.
- Capture stores fwd(in_rs_idx, in_rs_val) and fwd(in_rt_idx, in_rt_val).
- While holding, the held rs/rt values are rewritten each cycle with fwd(held_idx, held_val). A producer that retires during a stall is therefore not lost.
- Operand outputs:
  - alu_a = fwd(held_rs_idx, held_rs_val), combinational.
  - alu_b = held_use_imm ? held_imm : fwd(held_rt_idx, held_rt_val).
  - out_store_data = fwd(held_rt_idx, held_rt_val).
- flush has priority over everything: out_valid=0 next cycle and any concurrent input is dropped, even if handshaked. in_ready is unaffected by flush.
- When out_valid=0, held data may be stale, but out_wen=0.
- stall_cnt increments when out_valid && !out_ready && !flush and wraps 0xFFFFFFFF -> 0.
- alu_op is passed unmodified; this stage never decodes it.

Decomposition:
- Shared package cpu_pkg holds the ALU opcode constants: ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SLTU=011, ALU_XOR=100, ALU_NOR=101, ALU_SUB=110, ALU_SLT=111. It also holds REG_IDX_W and the value for the zero register index.
- Sub-module fwd_mux: combinational forward function, instantiated for rs and rt.

Test Plan:
- Reset then single instruction. Stimulus: rst pulse; rs=3 (val 0x10), rt=4 (val 0x20), op=ALU_ADD, use_imm=0, out_ready=1. Required: next cycle out_valid=1, alu_a=0x10, alu_b=0x20, alu_op=010; the cycle after, out_valid=0.
- MEM-over-WB priority. Stimulus: capture rs=5 (rf val 1) while MEM writes r5=0xAA and WB writes r5=0xBB. Required: alu_a=0xAA.
- Zero register. Stimulus: rs=0 while MEM writes idx 0 with 0x55. Required: alu_a = rf value 0.
- Stall refresh. Stimulus: hold with out_ready=0 for 3 cycles; in cycle 2 WB writes r4=0x77 for held rt=4. Required: alu_b=0x77 from cycle 2 on and after release; stall_cnt=3; in_ready=0 throughout the stall.
- Flush. Stimulus: flush asserted with in_valid=1 and a held instruction. Required: next cycle out_valid=0, out_wen=0, incoming instruction dropped.
- Async reset mid-stall. Stimulus: rst asserted between clock edges. Required: out_valid=0 and stall_cnt=0 immediately, before the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, register index width and the zero register.
package cpu_pkg;

   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned REG_ZERO  = 0;

   typedef enum logic [2:0] {
      ALU_AND  = 3'b000,
      ALU_OR   = 3'b001,
      ALU_ADD  = 3'b010,
      ALU_SLTU = 3'b011,
      ALU_XOR  = 3'b100,
      ALU_NOR  = 3'b101,
      ALU_SUB  = 3'b110,
      ALU_SLT  = 3'b111
   } alu_op_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: MEM result beats WB result, register zero is never forwarded.
module fwd_mux #(
   parameter bit          FWD_EN    = 1'b1,
   parameter int unsigned REG_IDX_W = cpu_pkg::REG_IDX_W
) (
   input  logic [REG_IDX_W-1:0] idx,
   input  logic [31:0]          val,
   input  logic                 mem_wen,
   input  logic [REG_IDX_W-1:0] mem_idx,
   input  logic [31:0]          mem_val,
   input  logic                 wb_wen,
   input  logic [REG_IDX_W-1:0] wb_idx,
   input  logic [31:0]          wb_val,
   output logic [31:0]          fwd_val
);
   import cpu_pkg::*;

   localparam logic [REG_IDX_W-1:0] ZERO_IDX = REG_IDX_W'(REG_ZERO);

   always_comb begin
      fwd_val = val;
      if (FWD_EN && (idx != ZERO_IDX)) begin
         if (mem_wen && (mem_idx == idx)) begin
            fwd_val = mem_val;
         end else if (wb_wen && (wb_idx == idx)) begin
            fwd_val = wb_val;
         end
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/execute pipeline register with valid/ready handshake, MEM/WB operand
// forwarding at capture and while held, and a stall-cycle counter.
module id_ex_stage #(
   parameter bit          FWD_EN    = 1'b1,
   parameter int unsigned REG_IDX_W = cpu_pkg::REG_IDX_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_pc,
   input  logic [REG_IDX_W-1:0] in_rs_idx,
   input  logic [REG_IDX_W-1:0] in_rt_idx,
   input  logic [REG_IDX_W-1:0] in_rd_idx,
   input  logic [31:0]          in_rs_val,
   input  logic [31:0]          in_rt_val,
   input  logic [31:0]          in_imm,
   input  logic                 in_use_imm,
   input  logic [2:0]           in_alu_op,
   input  logic                 in_wen,
   input  logic                 fwd_mem_wen,
   input  logic [REG_IDX_W-1:0] fwd_mem_idx,
   input  logic [31:0]          fwd_mem_val,
   input  logic                 fwd_wb_wen,
   input  logic [REG_IDX_W-1:0] fwd_wb_idx,
   input  logic [31:0]          fwd_wb_val,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          alu_a,
   output logic [31:0]          alu_b,
   output logic [2:0]           alu_op,
   output logic [31:0]          out_store_data,
   output logic [REG_IDX_W-1:0] out_rd_idx,
   output logic                 out_wen,
   output logic [31:0]          out_pc,
   output logic [31:0]          stall_cnt
);
   import cpu_pkg::*;

   logic                 valid_q, valid_d;
   logic [31:0]          pc_q, pc_d;
   logic [REG_IDX_W-1:0] rs_idx_q, rs_idx_d;
   logic [REG_IDX_W-1:0] rt_idx_q, rt_idx_d;
   logic [REG_IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic [31:0]          rs_val_q, rs_val_d;
   logic [31:0]          rt_val_q, rt_val_d;
   logic [31:0]          imm_q, imm_d;
   logic                 use_imm_q, use_imm_d;
   alu_op_e              alu_op_q, alu_op_d;
   logic                 wen_q, wen_d;
   logic [31:0]          stall_cnt_q, stall_cnt_d;

   logic [31:0] in_rs_fwd, in_rt_fwd;
   logic [31:0] held_rs_fwd, held_rt_fwd;
   logic        accept;

   fwd_mux #(.FWD_EN(FWD_EN), .REG_IDX_W(REG_IDX_W)) u_fwd_in_rs (
      .idx(in_rs_idx), .val(in_rs_val),
      .mem_wen(fwd_mem_wen), .mem_idx(fwd_mem_idx), .mem_val(fwd_mem_val),
      .wb_wen(fwd_wb_wen), .wb_idx(fwd_wb_idx), .wb_val(fwd_wb_val),
      .fwd_val(in_rs_fwd)
   );

   fwd_mux #(.FWD_EN(FWD_EN), .REG_IDX_W(REG_IDX_W)) u_fwd_in_rt (
      .idx(in_rt_idx), .val(in_rt_val),
      .mem_wen(fwd_mem_wen), .mem_idx(fwd_mem_idx), .mem_val(fwd_mem_val),
      .wb_wen(fwd_wb_wen), .wb_idx(fwd_wb_idx), .wb_val(fwd_wb_val),
      .fwd_val(in_rt_fwd)
   );

   fwd_mux #(.FWD_EN(FWD_EN), .REG_IDX_W(REG_IDX_W)) u_fwd_held_rs (
      .idx(rs_idx_q), .val(rs_val_q),
      .mem_wen(fwd_mem_wen), .mem_idx(fwd_mem_idx), .mem_val(fwd_mem_val),
      .wb_wen(fwd_wb_wen), .wb_idx(fwd_wb_idx), .wb_val(fwd_wb_val),
      .fwd_val(held_rs_fwd)
   );

   fwd_mux #(.FWD_EN(FWD_EN), .REG_IDX_W(REG_IDX_W)) u_fwd_held_rt (
      .idx(rt_idx_q), .val(rt_val_q),
      .mem_wen(fwd_mem_wen), .mem_idx(fwd_mem_idx), .mem_val(fwd_mem_val),
      .wb_wen(fwd_wb_wen), .wb_idx(fwd_wb_idx), .wb_val(fwd_wb_val),
      .fwd_val(held_rt_fwd)
   );

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      valid_d     = valid_q;
      pc_d        = pc_q;
      rs_idx_d    = rs_idx_q;
      rt_idx_d    = rt_idx_q;
      rd_idx_d    = rd_idx_q;
      // Held operands re-absorb any retiring producer every cycle.
      rs_val_d    = held_rs_fwd;
      rt_val_d    = held_rt_fwd;
      imm_d       = imm_q;
      use_imm_d   = use_imm_q;
      alu_op_d    = alu_op_q;
      wen_d       = wen_q;
      stall_cnt_d = stall_cnt_q;

      if (valid_q && !out_ready && !flush) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end

      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d   = 1'b1;
         pc_d      = in_pc;
         rs_idx_d  = in_rs_idx;
         rt_idx_d  = in_rt_idx;
         rd_idx_d  = in_rd_idx;
         rs_val_d  = in_rs_fwd;
         rt_val_d  = in_rt_fwd;
         imm_d     = in_imm;
         use_imm_d = in_use_imm;
         alu_op_d  = alu_op_e'(in_alu_op);
         wen_d     = in_wen;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         rs_idx_q    <= '0;
         rt_idx_q    <= '0;
         rd_idx_q    <= '0;
         rs_val_q    <= '0;
         rt_val_q    <= '0;
         imm_q       <= '0;
         use_imm_q   <= 1'b0;
         alu_op_q    <= ALU_AND;
         wen_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         pc_q        <= pc_d;
         rs_idx_q    <= rs_idx_d;
         rt_idx_q    <= rt_idx_d;
         rd_idx_q    <= rd_idx_d;
         rs_val_q    <= rs_val_d;
         rt_val_q    <= rt_val_d;
         imm_q       <= imm_d;
         use_imm_q   <= use_imm_d;
         alu_op_q    <= alu_op_d;
         wen_q       <= wen_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid      = valid_q;
   assign alu_a          = held_rs_fwd;
   assign alu_b          = use_imm_q ? imm_q : held_rt_fwd;
   assign out_store_data = held_rt_fwd;
   assign alu_op         = alu_op_q;
   assign out_rd_idx     = rd_idx_q;
   assign out_wen        = valid_q && wen_q;
   assign out_pc         = pc_q;
   assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for capture/forwarding, plus
// hand-written stall, flush and asynchronous-reset sequences.
module tb_id_ex_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_rs_idx, in_rt_idx, in_rd_idx;
   logic [31:0] in_rs_val, in_rt_val, in_imm;
   logic        in_use_imm;
   logic [2:0]  in_alu_op;
   logic        in_wen;
   logic        fwd_mem_wen;
   logic [4:0]  fwd_mem_idx;
   logic [31:0] fwd_mem_val;
   logic        fwd_wb_wen;
   logic [4:0]  fwd_wb_idx;
   logic [31:0] fwd_wb_val;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] alu_a, alu_b, out_store_data, out_pc, stall_cnt;
   logic [2:0]  alu_op;
   logic [4:0]  out_rd_idx;
   logic        out_wen;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.FWD_EN(1'b1), .REG_IDX_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
      .in_use_imm(in_use_imm), .in_alu_op(in_alu_op), .in_wen(in_wen),
      .fwd_mem_wen(fwd_mem_wen), .fwd_mem_idx(fwd_mem_idx), .fwd_mem_val(fwd_mem_val),
      .fwd_wb_wen(fwd_wb_wen), .fwd_wb_idx(fwd_wb_idx), .fwd_wb_val(fwd_wb_val),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .out_store_data(out_store_data), .out_rd_idx(out_rd_idx),
      .out_wen(out_wen), .out_pc(out_pc), .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rs_idx;
      logic [31:0] rs_val;
      logic [4:0]  rt_idx;
      logic [31:0] rt_val;
      logic [31:0] imm;
      logic        use_imm;
      logic [2:0]  op;
      logic        wen;
      logic [4:0]  rd;
      logic        mem_wen;
      logic [4:0]  mem_idx;
      logic [31:0] mem_val;
      logic        wb_wen;
      logic [4:0]  wb_idx;
      logic [31:0] wb_val;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [31:0] exp_sd;
      logic        exp_wen;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_pc = '0; in_rs_idx = '0; in_rt_idx = '0; in_rd_idx = '0;
      in_rs_val = '0; in_rt_val = '0; in_imm = '0; in_use_imm = 1'b0;
      in_alu_op = '0; in_wen = 1'b0; flush = 1'b0;
      fwd_mem_wen = 1'b0; fwd_mem_idx = '0; fwd_mem_val = '0;
      fwd_wb_wen = 1'b0; fwd_wb_idx = '0; fwd_wb_val = '0;
   endtask

   task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs, input logic [31:0] rsv,
                              input logic [4:0] rt, input logic [31:0] rtv, input logic [2:0] op);
      in_valid = 1'b1; in_pc = pc; in_rs_idx = rs; in_rs_val = rsv;
      in_rt_idx = rt; in_rt_val = rtv; in_alu_op = op; in_use_imm = 1'b0;
      in_imm = '0; in_wen = 1'b1; in_rd_idx = 5'd9;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] s0;

      // pc, rs, rsv, rt, rtv, imm, use_imm, op, wen, rd, mem(wen,idx,val), wb(wen,idx,val), exp a,b,sd,wen
      vecs[0] = '{32'h100, 5'd3, 32'h10, 5'd4, 32'h20, 32'h0, 1'b0, 3'b010, 1'b1, 5'd7,
                  1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h10, 32'h20, 32'h20, 1'b1};
      vecs[1] = '{32'h104, 5'd5, 32'h1, 5'd6, 32'h2, 32'h0, 1'b0, 3'b001, 1'b1, 5'd8,
                  1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 32'hAA, 32'h2, 32'h2, 1'b1};
      vecs[2] = '{32'h108, 5'd0, 32'h0, 5'd1, 32'h3, 32'h0, 1'b0, 3'b100, 1'b1, 5'd2,
                  1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 32'h0, 32'h3, 32'h3, 1'b1};
      vecs[3] = '{32'h10C, 5'd1, 32'h5, 5'd6, 32'h1, 32'h0, 1'b0, 3'b011, 1'b1, 5'd3,
                  1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 32'h5, 32'h66, 32'h66, 1'b1};
      vecs[4] = '{32'h110, 5'd7, 32'h7, 5'd2, 32'h22, 32'hFFFF_FFF0, 1'b1, 3'b110, 1'b0, 5'd4,
                  1'b1, 5'd2, 32'h99, 1'b0, 5'd0, 32'h0, 32'h7, 32'hFFFF_FFF0, 32'h99, 1'b0};
      vecs[5] = '{32'h114, 5'd8, 32'h8, 5'd9, 32'h9, 32'h0, 1'b0, 3'b111, 1'b1, 5'd31,
                  1'b0, 5'd8, 32'hDEAD, 1'b1, 5'd8, 32'h88, 32'h88, 32'h9, 32'h9, 1'b1};

      idle_inputs();
      out_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
      chk("reset_stall_cnt", stall_cnt, 32'h0);
      chk("reset_alu_op", {29'b0, alu_op}, {29'b0, ALU_AND});
      chk("reset_out_pc", out_pc, 32'h0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_pc = vecs[i].pc;
         in_rs_idx = vecs[i].rs_idx; in_rs_val = vecs[i].rs_val;
         in_rt_idx = vecs[i].rt_idx; in_rt_val = vecs[i].rt_val;
         in_imm = vecs[i].imm; in_use_imm = vecs[i].use_imm;
         in_alu_op = vecs[i].op; in_wen = vecs[i].wen; in_rd_idx = vecs[i].rd;
         fwd_mem_wen = vecs[i].mem_wen; fwd_mem_idx = vecs[i].mem_idx; fwd_mem_val = vecs[i].mem_val;
         fwd_wb_wen = vecs[i].wb_wen; fwd_wb_idx = vecs[i].wb_idx; fwd_wb_val = vecs[i].wb_val;
         step();
         // Forward sources go quiet so outputs reflect what was captured.
         idle_inputs();
         #1;
         chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'h1);
         chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].exp_a);
         chk($sformatf("v%0d_alu_b", i), alu_b, vecs[i].exp_b);
         chk($sformatf("v%0d_store", i), out_store_data, vecs[i].exp_sd);
         chk($sformatf("v%0d_alu_op", i), {29'b0, alu_op}, {29'b0, vecs[i].op});
         chk($sformatf("v%0d_out_wen", i), {31'b0, out_wen}, {31'b0, vecs[i].exp_wen});
         chk($sformatf("v%0d_rd", i), {27'b0, out_rd_idx}, {27'b0, vecs[i].rd});
         chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
         step();
         chk($sformatf("v%0d_drained", i), {31'b0, out_valid}, 32'h0);
         chk($sformatf("v%0d_drained_wen", i), {31'b0, out_wen}, 32'h0);
      end
      chk("no_stall_count", stall_cnt, 32'h0);

      // Stall with a WB producer retiring mid-stall.
      s0 = stall_cnt;
      @(negedge clk);
      out_ready = 1'b0;
      drive_instr(32'h200, 5'd3, 32'h10, 5'd4, 32'h20, ALU_ADD);
      step();
      drive_instr(32'h204, 5'd10, 32'h900, 5'd11, 32'hB00, ALU_OR);
      #1;
      chk("stall1_in_ready", {31'b0, in_ready}, 32'h0);
      chk("stall1_alu_b", alu_b, 32'h20);
      step();
      fwd_wb_wen = 1'b1; fwd_wb_idx = 5'd4; fwd_wb_val = 32'h77;
      #1;
      chk("stall2_in_ready", {31'b0, in_ready}, 32'h0);
      chk("stall2_alu_b", alu_b, 32'h77);
      step();
      fwd_wb_wen = 1'b0; fwd_wb_idx = '0; fwd_wb_val = '0;
      #1;
      chk("stall3_in_ready", {31'b0, in_ready}, 32'h0);
      chk("stall3_alu_b", alu_b, 32'h77);
      chk("stall3_alu_a", alu_a, 32'h10);
      step();
      out_ready = 1'b1;
      #1;
      chk("release_stall_cnt", stall_cnt, s0 + 32'd3);
      chk("release_alu_b", alu_b, 32'h77);
      chk("release_store", out_store_data, 32'h77);
      chk("release_in_ready", {31'b0, in_ready}, 32'h1);
      step();
      in_valid = 1'b0;
      #1;
      chk("next_instr_pc", out_pc, 32'h204);
      chk("next_instr_alu_a", alu_a, 32'h900);
      step();
      chk("post_stall_drain", {31'b0, out_valid}, 32'h0);

      // Flush with a held instruction and a concurrent handshake.
      @(negedge clk);
      out_ready = 1'b0;
      drive_instr(32'h300, 5'd1, 32'h1, 5'd2, 32'h2, ALU_XOR);
      step();
      drive_instr(32'h304, 5'd3, 32'h3, 5'd4, 32'h4, ALU_NOR);
      out_ready = 1'b1;
      flush = 1'b1;
      #1;
      chk("flush_held_valid", {31'b0, out_valid}, 32'h1);
      chk("flush_in_ready", {31'b0, in_ready}, 32'h1);
      step();
      idle_inputs();
      #1;
      chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
      chk("flush_out_wen", {31'b0, out_wen}, 32'h0);
      chk("flush_pc_not_taken", out_pc, 32'h300);
      step();
      chk("flush_stays_empty", {31'b0, out_valid}, 32'h0);

      // Asynchronous reset between edges during a stall.
      @(negedge clk);
      out_ready = 1'b0;
      drive_instr(32'h400, 5'd5, 32'h5, 5'd6, 32'h6, ALU_SUB);
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("pre_reset_stall_nonzero", {31'b0, (stall_cnt != 32'h0)}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("async_rst_stall_cnt", stall_cnt, 32'h0);
      chk("async_rst_out_wen", {31'b0, out_wen}, 32'h0);
      chk("async_rst_alu_op", {29'b0, alu_op}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      chk("post_reset_idle", {31'b0, out_valid}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
